// File: rtl/soc_sram.sv
// rtl/soc_sram.sv - dual-port 64-bit SRAM (32-bit inst port, 64-bit data port)
// Define SOC_SRAM_ERR_TRAP_EN to trap out-of-range accesses; otherwise the word index wraps.
module soc_sram #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [7:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        err_valid,
  output logic [31:0] err_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] d_idx;
  logic [AW-1:0] i_idx;
  logic          d_ok;
  logic          i_ok;
  logic [7:0]    i_be;
  logic [63:0]   i_wd;
  logic [63:0]   d_word;
  logic [63:0]   i_word;

  // Index is taken modulo DEPTH; the range check below decides whether it is honoured.
  assign d_idx = AW'((data_sram_addr - BASE_ADDR) >> 3);
  assign i_idx = AW'((inst_sram_addr - BASE_ADDR) >> 3);

`ifdef SOC_SRAM_ERR_TRAP_EN
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(8 * DEPTH);

  assign d_ok = (data_sram_addr >= BASE_ADDR) && ({1'b0, data_sram_addr} < LIMIT);
  assign i_ok = (inst_sram_addr >= BASE_ADDR) && ({1'b0, inst_sram_addr} < LIMIT);
`else
  assign d_ok = 1'b1;
  assign i_ok = 1'b1;
`endif

  assign i_be   = inst_sram_addr[2] ? {inst_sram_wen, 4'b0000} : {4'b0000, inst_sram_wen};
  assign i_wd   = {inst_sram_wdata, inst_sram_wdata};
  assign d_word = mem[d_idx];
  assign i_word = mem[i_idx];

  // No reset on the array: contents survive reset, and edges seen while reset is high are ignored.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int b = 0; b < 8; b++) begin
        if (inst_sram_en && i_ok && i_be[b] &&
            !(data_sram_en && d_ok && data_sram_wen[b] && (d_idx == i_idx)))
          mem[i_idx][8*b +: 8] <= i_wd[8*b +: 8];
        if (data_sram_en && d_ok && data_sram_wen[b])
          mem[d_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else begin
      if (data_sram_en)
        data_sram_rdata <= d_ok ? d_word : '0;
      if (inst_sram_en)
        inst_sram_rdata <= i_ok ? (inst_sram_addr[2] ? i_word[63:32] : i_word[31:0]) : '0;
    end
  end

`ifdef SOC_SRAM_ERR_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (!err_valid) begin
      if (data_sram_en && !d_ok) begin
        err_valid <= 1'b1;
        err_addr  <= data_sram_addr;
      end else if (inst_sram_en && !i_ok) begin
        err_valid <= 1'b1;
        err_addr  <= inst_sram_addr;
      end
    end
  end
`else
  assign err_valid = 1'b0;
  assign err_addr  = '0;
`endif

endmodule

// File: doc/soc_sram.md
SOC_SRAM -- requirements
Module: soc_sram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 4096, number of 64-bit words (power of two).
REQ-003 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port inst_sram_en, input, 1, inst port access request.
REQ-006 SHALL have port inst_sram_wen, input, 4, inst byte write enables.
REQ-007 SHALL have port inst_sram_addr, input, 32, inst byte address.
REQ-008 SHALL have port inst_sram_wdata, input, 32, inst write data.
REQ-009 SHALL have port inst_sram_rdata, output, 32, inst read data.
REQ-010 SHALL have port data_sram_en, input, 1, data port access request.
REQ-011 SHALL have port data_sram_wen, input, 8, data byte write enables.
REQ-012 SHALL have port data_sram_addr, input, 32, data byte address.
REQ-013 SHALL have port data_sram_wdata, input, 64, data write data.
REQ-014 SHALL have port data_sram_rdata, output, 64, data read data.
REQ-015 SHALL have port err_valid, output, 1, sticky out-of-range flag.
REQ-016 SHALL have port err_addr, output, 32, first out-of-range address.

Function
REQ-017 SHALL store DEPTH x 64-bit words; word index = (addr - BASE_ADDR) >> 3; addr[2:0] ignored by data port.
REQ-018 Inst port SHALL select 32-bit half by addr[2] (0 = bytes 3:0, 1 = bytes 7:4); inst_sram_wen[i] maps to byte 4*addr[2]+i.
REQ-019 Read latency SHALL be exactly one cycle: rdata registered at the edge where en=1; rdata holds its value while en=0.
REQ-020 Writes SHALL update only enabled bytes at the edge where en=1 and wen!=0; a write access also updates rdata (read-first, pre-write contents).
REQ-021 Read-during-write to same word from the other port SHALL return pre-write contents.
REQ-022 Both ports writing same byte same cycle SHALL resolve data-port-wins; non-overlapping bytes both commit.
REQ-023 An access is out of range when addr < BASE_ADDR or addr >= BASE_ADDR + 8*DEPTH.
REQ-024 Out-of-range handling SHALL follow REQ-030/031.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-026 On reset assertion, inst_sram_rdata and data_sram_rdata SHALL clear to 0 immediately (asynchronous).
REQ-027 On reset, err_valid SHALL clear to 0 and err_addr to 32'h0.
REQ-028 Accesses presented while reset=1 SHALL be ignored; first effective edge is the first rising edge after deassertion.
REQ-029 Reset asserted mid-access SHALL abort it; a write sampled on the same edge as reset assertion SHALL NOT commit.

Configuration
REQ-030 With SOC_SRAM_ERR_TRAP_EN defined: out-of-range writes dropped, reads return 0, err_valid set next edge and held until reset, err_addr captures first offending address (data port wins if both err same cycle).
REQ-031 Without SOC_SRAM_ERR_TRAP_EN: index wraps modulo DEPTH (no range check), err_valid and err_addr tied to 0.

Verification
REQ-032 Data write addr 0x8000_0010, wen 8'hFF, wdata 64'h1122334455667788; next cycle read -> data_sram_rdata 64'h1122334455667788 one cycle after en.
REQ-033 Data write wen 8'h0F wdata 64'hAAAA_AAAA_BBBB_BBBB over 0 at 0x8000_0020; inst read 0x8000_0020 -> 32'hBBBB_BBBB, inst read 0x8000_0024 -> 32'h0.
REQ-034 Same cycle inst write 32'h1234_5678 wen 4'hF @0x8000_0008 and data write 64'h0 wen 8'h01 @0x8000_0008 -> later read 64'h0000_0000_1234_5600.
REQ-035 With SOC_SRAM_ERR_TRAP_EN, data read 0x7FFF_FFF8 then 0x9000_0000 -> rdata 0, err_valid=1, err_addr=0x7FFF_FFF8 retained.
REQ-036 Write pending when reset asserts mid-cycle -> rdata 0 immediately; post-reset read shows old contents unchanged.
